// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_pkg
//  Description : Shared encodings for the writeback (commit) stage:
//                destination kinds, access widths, GPR indices, reset
//                EFLAGS value, FSM state type and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_pkg;

  // Destination kind encoding (reserved 11 behaves as "none")
  localparam logic [1:0] DEST_KIND_NONE = 2'b00;
  localparam logic [1:0] DEST_KIND_REG  = 2'b01;
  localparam logic [1:0] DEST_KIND_MEM  = 2'b10;
  localparam logic [1:0] DEST_KIND_RSVD = 2'b11;

  // Access width encoding (reserved 11 behaves as dword)
  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_WORD  = 2'b01;
  localparam logic [1:0] WIDTH_DWORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD  = 2'b11;

  // GPR indices
  localparam logic [2:0] GPR_EAX = 3'd0;
  localparam logic [2:0] GPR_ECX = 3'd1;
  localparam logic [2:0] GPR_EDX = 3'd2;
  localparam logic [2:0] GPR_EBX = 3'd3;
  localparam logic [2:0] GPR_ESP = 3'd4;
  localparam logic [2:0] GPR_EBP = 3'd5;
  localparam logic [2:0] GPR_ESI = 3'd6;
  localparam logic [2:0] GPR_EDI = 3'd7;

  // Bit 1 of EFLAGS is architecturally reserved as one
  localparam logic [31:0] EFLAGS_RESET_VALUE = 32'h0000_0002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ST0  = 2'd1,
    ST_ST1  = 2'd2
  } wb_state_e;

  // One decoded destination together with the value to be written to it
  typedef struct packed {
    logic [31:0] value;
    logic [1:0]  kind;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [1:0]  width;
  } dest_t;

  // Store byte enables for an access width
  function automatic logic [3:0] width_strb(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: width_strb = 4'b0001;
      WIDTH_WORD: width_strb = 4'b0011;
      default:    width_strb = 4'b1111;
    endcase
  endfunction

  // Byte writes with sel 4..7 address AH/CH/DH/BH, i.e. GPR sel-4
  function automatic logic [2:0] gpr_target(input logic [2:0] sel,
                                            input logic [1:0] width);
    if (width == WIDTH_BYTE) gpr_target = {1'b0, sel[1:0]};
    else                     gpr_target = sel;
  endfunction

  function automatic logic byte_high(input logic [2:0] sel,
                                     input logic [1:0] width);
    byte_high = (width == WIDTH_BYTE) && sel[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_regfile_wr.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile_wr
//  Description : Combinational partial-register merge. Produces the new
//                value of one 32-bit GPR after a byte/word/dword write.
//  Ports       : old_reg  - current register contents
//                value    - value being written (LSB-aligned)
//                width    - access width (11 treated as dword)
//                byte_hi  - byte write targets bits 15:8 (AH/CH/DH/BH)
//                new_reg  - merged register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile_wr
  import writeback_pkg::*;
(
  input  logic [31:0] old_reg,
  input  logic [31:0] value,
  input  logic [1:0]  width,
  input  logic        byte_hi,
  output logic [31:0] new_reg
);

  always_comb begin
    new_reg = old_reg;
    case (width)
      WIDTH_BYTE: begin
        if (byte_hi) new_reg[15:8] = value[7:0];
        else         new_reg[7:0]  = value[7:0];
      end
      WIDTH_WORD: new_reg[15:0] = value[15:0];
      default:    new_reg       = value;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
//  Module      : writeback
//  Description : Commit stage. Accepts one executed step, serializes up to
//                two memory stores over a valid/ready port, then commits
//                GPRs, EFLAGS and EIP atomically and pulses retire.
//  Ports       : clk/rst           - clock, synchronous active-high reset
//                in_valid/in_ready - step handshake from execute
//                opnd0_w/opnd1_w   - values for destination 0/1
//                o_eflags/next_eip - new EFLAGS / EIP
//                dest{0,1}_*       - destination kind/sel/addr/width
//                mem_wr_*          - store request port
//                gprs/eflags/eip   - architectural state ({EDI..EAX})
//                retire/retire_count - commit pulse and commit counter
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback
  import writeback_pkg::*;
#(
  parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
  parameter logic [31:0] RESET_ESP    = 32'h0000_0000,
  parameter logic [31:0] RESET_EFLAGS = EFLAGS_RESET_VALUE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  opnd0_w,
  input  logic [31:0]  opnd1_w,
  input  logic [31:0]  o_eflags,
  input  logic [31:0]  next_eip,
  input  logic [1:0]   dest0_kind,
  input  logic [1:0]   dest1_kind,
  input  logic [2:0]   dest0_sel,
  input  logic [2:0]   dest1_sel,
  input  logic [31:0]  dest0_addr,
  input  logic [31:0]  dest1_addr,
  input  logic [1:0]   dest0_width,
  input  logic [1:0]   dest1_width,
  output logic         mem_wr_valid,
  input  logic         mem_wr_ready,
  output logic [31:0]  mem_wr_addr,
  output logic [31:0]  mem_wr_data,
  output logic [3:0]   mem_wr_strb,
  output logic [255:0] gprs,
  output logic [31:0]  eflags,
  output logic [31:0]  eip,
  output logic         retire,
  output logic [31:0]  retire_count
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wb_state_e   state_q, state_d;

  dest_t       dest0_q, dest0_d;
  dest_t       dest1_q, dest1_d;
  logic [31:0] new_eflags_q, new_eflags_d;
  logic [31:0] new_eip_q, new_eip_d;

  logic [31:0] gpr_q [8];
  logic [31:0] gpr_d [8];
  logic [31:0] eflags_q, eflags_d;
  logic [31:0] eip_q, eip_d;
  logic        retire_q, retire_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic        load;
  logic        commit;

  // --------------------------------------------------------------------------
  // Commit source: in IDLE a register-only step commits on its accept edge,
  // so the live inputs are used; otherwise the latched step is used.
  // --------------------------------------------------------------------------
  dest_t       dest0_in, dest1_in;
  dest_t       src0, src1;
  logic [31:0] src_eflags, src_eip;

  assign dest0_in = '{value: opnd0_w, kind: dest0_kind, sel: dest0_sel,
                      addr: dest0_addr, width: dest0_width};
  assign dest1_in = '{value: opnd1_w, kind: dest1_kind, sel: dest1_sel,
                      addr: dest1_addr, width: dest1_width};

  always_comb begin
    if (state_q == ST_IDLE) begin
      src0       = dest0_in;
      src1       = dest1_in;
      src_eflags = o_eflags;
      src_eip    = next_eip;
    end else begin
      src0       = dest0_q;
      src1       = dest1_q;
      src_eflags = new_eflags_q;
      src_eip    = new_eip_q;
    end
  end

  // --------------------------------------------------------------------------
  // Register-file merge, chained so dest1 sees dest0's result and wins on
  // any overlapping bytes.
  // --------------------------------------------------------------------------
  logic [2:0]  tgt0, tgt1;
  logic [31:0] merged0, merged1;
  logic [31:0] old1;
  logic [31:0] gpr_mid [8];

  assign tgt0 = gpr_target(src0.sel, src0.width);
  assign tgt1 = gpr_target(src1.sel, src1.width);

  writeback_regfile_wr u_merge0 (
    .old_reg (gpr_q[tgt0]),
    .value   (src0.value),
    .width   (src0.width),
    .byte_hi (byte_high(src0.sel, src0.width)),
    .new_reg (merged0)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) gpr_mid[i] = gpr_q[i];
    if (src0.kind == DEST_KIND_REG) gpr_mid[tgt0] = merged0;
  end

  assign old1 = gpr_mid[tgt1];

  writeback_regfile_wr u_merge1 (
    .old_reg (old1),
    .value   (src1.value),
    .width   (src1.width),
    .byte_hi (byte_high(src1.sel, src1.width)),
    .new_reg (merged1)
  );

  // --------------------------------------------------------------------------
  // FSM next state and store port
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = dest0_q.addr;
    mem_wr_data  = dest0_q.value;
    mem_wr_strb  = width_strb(dest0_q.width);
    load         = 1'b0;
    commit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          if (dest0_kind == DEST_KIND_MEM)      state_d = ST_ST0;
          else if (dest1_kind == DEST_KIND_MEM) state_d = ST_ST1;
          else                                  commit  = 1'b1;
        end
      end
      ST_ST0: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready) begin
          if (dest1_q.kind == DEST_KIND_MEM) begin
            state_d = ST_ST1;
          end else begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ST1: begin
        mem_wr_valid = 1'b1;
        mem_wr_addr  = dest1_q.addr;
        mem_wr_data  = dest1_q.value;
        mem_wr_strb  = width_strb(dest1_q.width);
        if (mem_wr_ready) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next values of latched step and architectural state
  // --------------------------------------------------------------------------
  always_comb begin
    dest0_d      = load ? dest0_in : dest0_q;
    dest1_d      = load ? dest1_in : dest1_q;
    new_eflags_d = load ? o_eflags : new_eflags_q;
    new_eip_d    = load ? next_eip : new_eip_q;

    for (int i = 0; i < 8; i++) gpr_d[i] = gpr_q[i];
    eflags_d       = eflags_q;
    eip_d          = eip_q;
    retire_d       = commit;
    retire_count_d = retire_count_q;

    if (commit) begin
      for (int i = 0; i < 8; i++) gpr_d[i] = gpr_mid[i];
      if (src1.kind == DEST_KIND_REG) gpr_d[tgt1] = merged1;
      eflags_d       = src_eflags;
      eip_d          = src_eip;
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dest0_q        <= '0;
      dest1_q        <= '0;
      new_eflags_q   <= '0;
      new_eip_q      <= '0;
      for (int i = 0; i < 8; i++)
        gpr_q[i] <= (3'(i) == GPR_ESP) ? RESET_ESP : 32'h0;
      eflags_q       <= RESET_EFLAGS;
      eip_q          <= RESET_EIP;
      retire_q       <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      dest0_q        <= dest0_d;
      dest1_q        <= dest1_d;
      new_eflags_q   <= new_eflags_d;
      new_eip_q      <= new_eip_d;
      for (int i = 0; i < 8; i++) gpr_q[i] <= gpr_d[i];
      eflags_q       <= eflags_d;
      eip_q          <= eip_d;
      retire_q       <= retire_d;
      retire_count_q <= retire_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 8; g++) begin : g_gprs_out
    assign gprs[g*32 +: 32] = gpr_q[g];
  end

  assign eflags       = eflags_q;
  assign eip          = eip_q;
  assign retire       = retire_q;
  assign retire_count = retire_count_q;

endmodule
`default_nettype wire

// File: doc/writeback.md
Name: writeback

Overview:
- Commit stage directly downstream of execute.
- Accepts one executed step: opnd0_w, opnd1_w, o_eflags and next_eip, plus the decoded destination descriptors for operands 0 and 1.
- Serializes up to two memory stores over a valid/ready port.
- Updates the architectural GPR file, EFLAGS and EIP atomically once all stores are accepted, then pulses retire.
- Owns the architectural state that decode reads for the next step.

Parameters:
- RESET_EIP, 32'h0000_0000, EIP value after reset.
- RESET_ESP, 32'h0000_0000, ESP (GPR 4) value after reset.
- RESET_EFLAGS, 32'h0000_0002, EFLAGS after reset (bit 1 reserved-one).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept a step.
- opnd0_w  in  32  write value for destination 0.
- opnd1_w  in  32  write value for destination 1.
- o_eflags  in  32  new EFLAGS.
- next_eip  in  32  new EIP.
- dest0_kind  in  2  00 none, 01 reg, 10 mem, 11 reserved (treated as none).
- dest1_kind  in  2  same encoding as dest0_kind.
- dest0_sel  in  3  GPR index when kind=reg.
- dest1_sel  in  3  GPR index when kind=reg.
- dest0_addr  in  32  store address when kind=mem.
- dest1_addr  in  32  store address when kind=mem.
- dest0_width  in  2  00 byte, 01 word, 10 dword.
- dest1_width  in  2  same encoding as dest0_width.
- mem_wr_valid  out  1  store request.
- mem_wr_ready  in  1  memory accepts store.
- mem_wr_addr  out  32  store address.
- mem_wr_data  out  32  store data, unshifted, LSB-aligned.
- mem_wr_strb  out  4  byte enables: 0001 byte, 0011 word, 1111 dword.
- gprs  out  256  {EDI..EAX}; EAX occupies bits 31:0.
- eflags  out  32  architectural EFLAGS.
- eip  out  32  architectural EIP.
- retire  out  1  one-cycle pulse when a step commits.
- retire_count  out  32  number of committed steps.

Behaviour:
- Reset values:
  - All GPRs 0, except ESP = RESET_ESP.
  - eflags = RESET_EFLAGS; eip = RESET_EIP.
  - FSM in IDLE; in_ready = 1; mem_wr_valid = 0; retire = 0; retire_count = 0.
- FSM states: IDLE, ST0, ST1.
- IDLE:
  - in_ready = 1. Accept occurs when in_valid & in_ready; latch all inputs.
  - Accept with no mem dest: commit on the same edge. New state is visible the next cycle; retire is high that cycle. Stay in IDLE, so back-to-back throughput is 1 step/cycle.
  - Accept with dest0 = mem: go to ST0.
  - Accept with only dest1 = mem: go to ST1.
- ST0:
  - mem_wr_valid = 1 carrying dest0 addr/data/strb; in_ready = 0.
  - On handshake: go to ST1 if dest1 = mem, otherwise commit and go to IDLE.
- ST1:
  - mem_wr_valid = 1 carrying dest1 addr/data/strb; in_ready = 0.
  - On handshake: commit and go to IDLE.
- mem_wr_* fields are stable while valid and not ready. Valid never drops without a handshake, except on rst.
- Commit (single edge):
  - eflags ← o_eflags; eip ← next_eip; retire_count += 1, wrapping at 2^32.
  - Apply reg dest0, then reg dest1. If both name the same GPR, dest1 wins on overlapping bytes.
- Reg write width rules:
  - dword: replaces the full register.
  - word: bits 15:0 only.
  - byte, sel 0–3: bits 7:0 of GPR sel.
  - byte, sel 4–7: bits 15:8 of GPR sel-4 (AH/CH/DH/BH).
  - Unwritten bits are preserved. Width 11 is treated as dword.
- Stores with a byte/word width send only the low bits of the value; upper data bits are don't-care and the strobe masks them.
- rst mid-store: the pending store is abandoned, mem_wr_valid = 0 the next cycle, and no partial commit occurs. Architectural state returns to reset values.
- rst has priority over a simultaneous accept or handshake.
- Architectural state changes only at commit. No state is visible between ST0 and ST1.

Decomposition:
- Shared defines header (beside the existing defines):
  - DEST_KIND_* and WIDTH_* encodings.
  - GPR indices (EAX=0 … EDI=7; ESP=4).
  - Reset EFLAGS constant.
- One sub-module, regfile_wr: a combinational merge taking old 32-bit reg, value, width and byte-high flag, returning the new reg. Instantiated twice, chained for dest0 then dest1.
- The FSM, store port and architectural registers live in writeback.

Test Plan:
- Reset, then idle → eip = 0, gprs[159:128] = RESET_ESP, eflags = 0x2, in_ready = 1, retire_count = 0.
- dest0 = reg sel 0 dword 0xDEADBEEF, dest1 = none, next_eip = 0x10 → the next cycle EAX = 0xDEADBEEF, eip = 0x10, retire = 1 for exactly one cycle, and back-to-back steps retire every cycle.
- Byte write sel 4 value 0x55 into EAX = 0x11223344 → EAX = 0x11225544. Word write value 0xAAAA to EBX = 0xFFFFFFFF → EBX = 0xFFFFAAAA.
- PUSH-style step: dest0 = mem addr 0x1000 dword 0xCAFEBABE, dest1 = reg ESP value 0xFFC, mem_wr_ready held low 3 cycles → request stable with strb 1111, in_ready = 0, ESP and eip unchanged until the handshake, then commit the next cycle.
- Two mem dests (0x100 byte 0x12, 0x200 word 0x3456) → stores issued in order with strb 0001 then 0011. One retire after the second handshake.
- rst asserted while in ST0 with ready low → mem_wr_valid = 0 the next cycle, state equals reset values, retire never pulses.
